pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
- Sequences the core's clock PLL on the 50 MHz reference-clock domain.
- Drives the PLL reset with a fixed-width pulse and synchronizes the asynchronous `locked` output.
- Holds the core in reset until lock has been stable for a set number of cycles.
- Re-arms the PLL on loss of lock or lock timeout, with bounded retries and a sticky failure state.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronizing locked_in (min 2).
- RST_PULSE, 16, cycles pll_rst is held high per PLL reset (min 1).
- LOCK_TIMEOUT, 1000000, cycles to wait for lock after pll_rst release before retrying (20 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive locked cycles required before core_reset releases (min 1).
- MAX_RETRIES, 7, lock-timeout retries allowed before entering FAIL.

Ports:
- clk  in  1  reference clock (50 MHz); all logic on this edge.
- rst  in  1  synchronous, active-high reset.
- locked_in  in  1  PLL locked output; asynchronous to clk.
- force_relock  in  1  single-cycle request to restart the PLL sequence.
- pll_rst  out  1  registered reset to PLL rst.
- core_reset  out  1  registered active-high reset for the core clock domains.
- fail  out  1  high while in FAIL.
- state_o  out  3  current state: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL.
- retry_cnt  out  3  lock timeouts since last RUN or force_relock.
- lost_count  out  8  saturating count of lock losses seen in RUN.

Behaviour:
- Synchronizer:
  - locked_sync is locked_in delayed through SYNC_STAGES flops.
  - Synchronizer flops reset to 0.
- Reset (rst=1 at an edge):
  - state=RESET_PLL, pll_rst=1, core_reset=1, fail=0.
  - retry_cnt=0, lost_count=0, all timers=0.
- All outputs are registered. A state's output values appear on the same edge the state is entered.
- RESET_PLL:
  - pll_rst=1, core_reset=1.
  - Stays exactly RST_PULSE cycles per entry, then goes to WAIT_LOCK with pll_rst=0.
- WAIT_LOCK:
  - pll_rst=0, core_reset=1; timer counts cycles.
  - locked_sync=1 goes to STABLE.
  - Otherwise, when the timer reaches LOCK_TIMEOUT-1:
    - If retry_cnt==MAX_RETRIES, go to FAIL.
    - Else retry_cnt+1 and go to RESET_PLL.
  - If lock and timeout occur in the same cycle, lock wins.
- STABLE:
  - core_reset=1; counts consecutive cycles with locked_sync=1.
  - locked_sync=0 goes to WAIT_LOCK with its timer restarted at 0; retry_cnt is unchanged.
  - After STABLE_CYCLES locked cycles, go to RUN.
  - core_reset therefore falls exactly STABLE_CYCLES+1 clocks after locked_sync first reads 1 in WAIT_LOCK.
- RUN:
  - core_reset=0, pll_rst=0; retry_cnt cleared to 0 on entry.
  - locked_sync=0 goes to RESET_PLL with core_reset=1 on that same edge, and lost_count+1 (saturating at 255).
- FAIL:
  - pll_rst=0, core_reset=1, fail=1.
  - Held until force_relock or rst.
- force_relock:
  - Highest priority after rst, in any state: next state RESET_PLL, retry_cnt=0, fail=0, RST_PULSE restarts.
  - If asserted in RUN in the same cycle as a lock loss, lost_count still increments.
  - If asserted during RESET_PLL, the pulse restarts from a full RST_PULSE.
- Counter widths:
  - Sized by $clog2 of the respective parameter.
  - No wrap inside a state: timers clear on every state entry.
- Glitches: a locked_in glitch shorter than one clk period may be missed. Only synchronized levels act.

Test Plan:
Bench uses SYNC_STAGES=2, RST_PULSE=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Power-up lock: rst, then locked_in rises 10 cycles after pll_rst falls.
  - pll_rst high exactly 4 cycles.
  - core_reset falls 2+8+1=11 cycles after locked_in rise.
  - state_o=3, retry_cnt=0.
- Lock loss in RUN: drop locked_in for 5 cycles.
  - core_reset rises 3 cycles after the drop; lost_count=1.
  - New 4-cycle pll_rst pulse, then normal re-entry to RUN.
- Timeout/fail: keep locked_in=0.
  - Three WAIT_LOCK windows of 32 cycles separated by two 4-cycle pll_rst pulses.
  - retry_cnt goes 1 then 2, then state_o=4 and fail=1; outputs hold for 100 cycles.
- Recovery: in FAIL, pulse force_relock with locked_in=1.
  - fail clears next edge, 4-cycle pll_rst pulse, RUN reached 4+1+8+... cycles later, retry_cnt=0.
- STABLE interruption: drop locked_in for 1 sync'd cycle at STABLE count 5.
  - Returns to WAIT_LOCK, no pll_rst pulse, retry_cnt unchanged.
  - Full 8-cycle count required again.
- Saturation/priority:
  - 300 lock losses in RUN give lost_count=255.
  - force_relock coinciding with a loss gives RESET_PLL and lost_count increments.
  - rst mid-WAIT_LOCK returns to reset values next edge.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - PLL supervisor control/status bundle
//
// Ports carried:
//   locked_in    PLL locked output, asynchronous to clk
//   force_relock single-cycle request to restart the PLL sequence
//   pll_rst      registered reset to the PLL
//   core_reset   registered active-high reset for the core clock domains
//   fail         high while the supervisor has given up
//   state_o      current state (0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL)
//   retry_cnt    lock timeouts since last RUN or force_relock
//   lost_count   saturating count of lock losses seen in RUN
// master drives the requests and observes status; slave is the supervisor.
interface pll_lock_supervisor_if;
  logic       locked_in;
  logic       force_relock;
  logic       pll_rst;
  logic       core_reset;
  logic       fail;
  logic [2:0] state_o;
  logic [2:0] retry_cnt;
  logic [7:0] lost_count;

  modport master (
    output locked_in, force_relock,
    input  pll_rst, core_reset, fail, state_o, retry_cnt, lost_count
  );

  modport slave (
    input  locked_in, force_relock,
    output pll_rst, core_reset, fail, state_o, retry_cnt, lost_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and retry supervisor
//
// Ports:
//   clk  reference clock; every flop is on its rising edge
//   rst  synchronous active-high reset
//   bus  pll_lock_supervisor_if.slave (locked_in, force_relock in;
//        pll_rst, core_reset, fail, state_o, retry_cnt, lost_count out)
module pll_lock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input logic                  clk,
  input logic                  rst,
  pll_lock_supervisor_if.slave bus
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // One timer serves every state because it is cleared on each state entry;
  // it only has to reach the largest terminal count minus one.
  localparam int MAX_A = (RST_PULSE > STABLE_CYCLES) ? RST_PULSE : STABLE_CYCLES;
  localparam int MAX_T = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_sync;

  state_t      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]  retry_q, retry_d;
  logic [7:0]  lost_q, lost_d;
  logic        lost_inc;
  logic        pll_rst_q, core_reset_q, fail_q;

  assign locked_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    retry_d  = retry_q;
    lost_d   = lost_q;
    lost_inc = 1'b0;

    case (state_q)
      RESET_PLL: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(RST_PULSE - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        timer_d = timer_q + TW'(1);
        // Lock takes precedence over a coincident timeout.
        if (locked_sync) begin
          state_d = STABLE;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          if (retry_q == 3'(MAX_RETRIES)) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + 3'd1;
            state_d = RESET_PLL;
          end
        end
      end
      STABLE: begin
        // Every cycle spent here was locked, so the timer is the run length.
        timer_d = timer_q + TW'(1);
        if (!locked_sync) state_d = WAIT_LOCK;
        else if (timer_q == TW'(STABLE_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        if (!locked_sync) begin
          state_d  = RESET_PLL;
          lost_inc = 1'b1;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: state_d = RESET_PLL;
    endcase

    if (bus.force_relock) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end

    // Re-entering RESET_PLL through force_relock is not a state change but
    // must still restart the pulse from zero.
    if (state_d != state_q || bus.force_relock) timer_d = '0;

    if (state_d == RUN && state_q != RUN) retry_d = '0;

    if (lost_inc && lost_q != 8'hFF) lost_d = lost_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= RESET_PLL;
      timer_q      <= '0;
      retry_q      <= '0;
      lost_q       <= '0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      fail_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.locked_in};
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
      // Outputs follow the next state so they change on the entry edge.
      pll_rst_q    <= (state_d == RESET_PLL);
      core_reset_q <= (state_d != RUN);
      fail_q       <= (state_d == FAIL);
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.core_reset = core_reset_q;
  assign bus.fail       = fail_q;
  assign bus.state_o    = state_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.lost_count = lost_q;

endmodule
